c3_src_buf_loader: RTL and testbench

- Write-side sequencer for the C3 source buffer bank: 6 feature maps of 14x14 16-bit words each.
- Accepts the S2-layer output as a valid/ready stream.
- Scatters the stream into the per-map buffers by generating the packed write address (map select in [15:8], in-map offset in [7:0]), the write data and the write enable.
- Holds the bank "full" until the C3 convolution engine releases it, so a reload cannot overwrite data still being read.

---
 rtl/c3_src_buf_loader.sv | 84 ++++++++
 tb/tb_c3_src_buf_loader.sv | 101 ++++++++++
 2 files changed

// File: rtl/c3_src_buf_loader.sv
// c3_src_buf_loader: scatters the S2 stream into the C3 source map buffers and holds the bank full until released.
module c3_src_buf_loader #(
  parameter int MAP_NUM    = 6,
  parameter int MAP_SIZE   = 196,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  release_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [31:0]           wr_addr_o,
  output logic                  we_o,
  output logic                  busy_o,
  output logic                  buf_full_o,
  output logic [15:0]           load_cnt_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FULL = 2'd2} state_t;
  state_t                state_q, state_d;
  logic [7:0]            map_q, map_d, off_q, off_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           addr_q, addr_d, cnt_q, cnt_d;
  logic                  acc, off_last, last;
  assign in_ready_o = (state_q == LOAD) && !abort_i;
  assign acc        = in_valid_i && in_ready_o;
  assign off_last   = off_q == 8'(MAP_SIZE - 1);
  assign last       = off_last && (map_q == 8'(MAP_NUM - 1));
  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    off_d   = off_q;
    we_d    = 1'b0;
    data_d  = data_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && start_i) begin
      state_d = LOAD;
      map_d   = 8'd0;
      off_d   = 8'd0;
      cnt_d   = 16'd0;
    end
    if (state_q == LOAD && abort_i) state_d = IDLE;
    if (acc) begin
      we_d   = 1'b1;
      data_d = in_data_i;
      addr_d = {map_q, off_q};
      cnt_d  = cnt_q + 16'd1;
      off_d  = off_last ? 8'd0 : off_q + 8'd1;
      map_d  = off_last ? (last ? 8'd0 : map_q + 8'd1) : map_q;
      if (last) state_d = FULL;
    end
    if (state_q == FULL && release_i) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      map_q   <= 8'd0;
      off_q   <= 8'd0;
      we_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= 16'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      off_q   <= off_d;
      we_q    <= we_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end
  assign wr_data_o  = data_q;
  assign wr_addr_o  = {16'h0000, addr_q};
  assign we_o       = we_q;
  assign busy_o     = state_q == LOAD;
  assign buf_full_o = state_q == FULL;
  assign load_cnt_o = cnt_q;
endmodule

// File: tb/tb_c3_src_buf_loader.sv
// tb_c3_src_buf_loader: randomized bench against a beat-count reference model of the loader.
module tb_c3_src_buf_loader;
  localparam int MAP_NUM = 6, MAP_SIZE = 196, TOTAL = MAP_NUM * MAP_SIZE;
  logic        clk = 0, rst_n = 0, start = 0, abort = 0, rel = 0, in_valid = 0;
  logic [15:0] in_data = 0, wr_data, load_cnt;
  logic [31:0] wr_addr;
  logic        in_ready, we, busy, buf_full;
  int          errs = 0, checks = 0;
  int          m_st = 0, m_n = 0, m_cnt = 0, m_we = 0, m_addr = 0, m_data = 0;
  c3_src_buf_loader dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .release_i(rel),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .wr_data_o(wr_data), .wr_addr_o(wr_addr), .we_o(we), .busy_o(busy),
    .buf_full_o(buf_full), .load_cnt_o(load_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic s, input logic a, input logic rl,
                     input logic v, input logic [15:0] d);
    logic ready;
    rst_n = r; start = s; abort = a; rel = rl; in_valid = v; in_data = d;
    #1;
    ready = (m_st == 1) && !a;
    chk("in_ready", in_ready, ready);
    m_we = 0;
    if (!r) begin
      m_st = 0; m_n = 0; m_cnt = 0; m_addr = 0; m_data = 0;
    end else if (m_st == 0) begin
      if (s) begin m_st = 1; m_n = 0; m_cnt = 0; end
    end else if (m_st == 1) begin
      if (a) m_st = 0;
      else if (v) begin
        m_we = 1; m_data = d;
        m_addr = ((m_n / MAP_SIZE) << 8) | (m_n % MAP_SIZE);
        m_n++; m_cnt = m_n;
        if (m_n == TOTAL) m_st = 2;
      end
    end else if (rl) m_st = 0;
    @(posedge clk); #1;
    chk("we", we, m_we);
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_data", wr_data, m_data);
    chk("busy", busy, m_st == 1);
    chk("buf_full", buf_full, m_st == 2);
    chk("load_cnt", load_cnt, m_cnt);
  endtask
  initial begin
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 16'hffff);
    cyc(1, 0, 1, 1, 1, 0);
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < TOTAL; i++) cyc(1, 1, 0, 1, 1, 16'(i));
    chk("last_addr", wr_addr, 32'h0000_05c3);
    chk("last_data", wr_data, 32'h0000_0497);
    chk("full_cnt", load_cnt, 32'd1176);
    chk("full_flag", buf_full, 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 1, 16'(i + 100));
    cyc(1, 1, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 16'h1111);
    cyc(1, 0, 0, 0, 0, 16'h2222);
    cyc(1, 0, 0, 0, 0, 16'h3333);
    cyc(1, 0, 0, 0, 1, 16'h4444);
    cyc(1, 0, 0, 0, 0, 0);
    chk("bubble_addr", wr_addr, 32'h0000_0001);
    for (int i = 2; i < 9; i++) cyc(1, 0, 0, 1, 1, 16'($urandom));
    cyc(1, 0, 1, 0, 1, 16'hdead);
    chk("abort_cnt", load_cnt, 32'd9);
    chk("abort_idle", busy, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 16'h0abc);
    chk("restart_addr", wr_addr, 32'h0000_0000);
    for (int i = 1; i < 50; i++) cyc(1, 0, 0, 0, 1, 16'($urandom));
    cyc(0, 0, 0, 0, 1, 16'hbeef);
    chk("rst_we", we, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_cnt", load_cnt, 0);
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4000 && m_st == 1; i++)
      cyc(1, $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 16'($urandom));
    for (int j = 0; j < 3; j++) begin
      cyc(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4000 && m_st == 1; i++)
        cyc(1, $urandom_range(0, 3) == 0, 1'b0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0, 16'($urandom));
      chk("rand_full", buf_full, 1);
      cyc(1, 1, 1, 1, 1, 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
